pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (IF, IF_ID, ID, ID_ALU, ALU, alu_mem, mem, mem_wb).
- Collects stall requests from ID (load-use) and ALU (multi-cycle op), branch/jump redirects from ALU, and halt from WB.
- Drives per-register stall and bubble vectors, the IF/ID flush and the PC redirect.
- Tracks halt state, flush extension and a stall watchdog.

Parameters:
- XLEN, 32, PC / redirect width.
- FLUSH_EXTRA, 0, extra cycles flush_o is held after a redirect (0..15; covers future fetch latency).
- STALL_TIMEOUT, 255, consecutive stallreq_ex cycles before timeout_err sets (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stallreq_id  in  1  ID load-use hazard, level
- stallreq_ex  in  1  ALU busy, held until result ready
- flush_req  in  1  ALU taken branch/jump, one-cycle pulse
- flush_pc  in  XLEN  redirect target, valid with flush_req
- halt_req  in  1  ebreak retired in WB, pulse
- stall_o  out  5  bit0 PC, bit1 IF_ID, bit2 ID_ALU, bit3 alu_mem, bit4 mem_wb; 1 = hold
- bubble_o  out  2  bit0 NOP into ID_ALU, bit1 NOP into alu_mem
- flush_o  out  1  clear IF_ID and ID_ALU to NOP
- redirect_valid_o  out  1  PC loads redirect_pc_o this edge
- redirect_pc_o  out  XLEN  redirect target
- halted_o  out  1  pipeline frozen
- timeout_err_o  out  1  sticky watchdog flag
- stall_cycles_o  out  32  perf counter (see Optional Feature)
- flush_count_o  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - State RUN; flush_cnt=0; wd_cnt=0.
  - All outputs 0; redirect_pc_o=0.
  - Reset overrides every request and clears the HALT state.
- FSM states: RUN, FLUSH, HALT. Stall decoding is combinational from inputs (zero latency) in RUN and FLUSH.
- Priority: halt_req > stallreq_ex > flush_req > stallreq_id.
- Combinational outputs in RUN and FLUSH:
  - halt_req=1: stall_o=5'b11111 this cycle; next state HALT.
  - stallreq_ex=1: stall_o=5'b00111, bubble_o=2'b10.
    - flush_req is ignored while stallreq_ex=1; ALU must not assert both.
  - flush_req=1 (and stallreq_ex=0):
    - flush_o=1, redirect_valid_o=1, redirect_pc_o=flush_pc, stall_o=0.
    - Any concurrent stallreq_id is discarded, because the stalled instruction is being killed.
    - If FLUSH_EXTRA>0: next state FLUSH, flush_cnt=FLUSH_EXTRA.
  - stallreq_id=1 only: stall_o=5'b00011, bubble_o=2'b01.
  - No request: all 0.
- FLUSH state:
  - flush_o=1 every cycle; flush_cnt decrements.
  - Returns to RUN when flush_cnt reaches 1 at the edge; total flush_o = 1+FLUSH_EXTRA cycles.
  - stallreq_id is ignored while in FLUSH.
  - A new flush_req reloads flush_cnt and updates the redirect (redirect_valid_o=1 that cycle).
  - stallreq_ex and halt_req are honoured as in RUN; a stall freezes flush_cnt.
- redirect_pc_o is held at its last value when redirect_valid_o=0.
- HALT state:
  - stall_o=5'b11111, halted_o=1, bubble_o=0, flush_o=0.
  - All requests ignored; exit only via rst.
- Watchdog:
  - wd_cnt increments each cycle stallreq_ex=1 and clears when stallreq_ex=0.
  - Saturates at STALL_TIMEOUT.
  - timeout_err_o sets the cycle after wd_cnt reaches STALL_TIMEOUT; it is sticky until rst.
  - The watchdog does not alter stall behaviour.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles_o counts cycles with stall_o[0]=1 outside HALT.
  - flush_count_o counts redirect_valid_o pulses.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Not defined: both ports tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all requests=1 -> every output 0, halted_o=0.
- Load-use: stallreq_id=1 for 1 cycle -> stall_o=5'b00011, bubble_o=2'b01 that cycle; next cycle all 0.
- Multi-cycle ALU: stallreq_ex=1 for 4 cycles with stallreq_id=1 and flush_req=1 -> stall_o=5'b00111, bubble_o=2'b10, flush_o=0 for all 4 cycles.
- Redirect with FLUSH_EXTRA=2: flush_req=1, flush_pc=0x80000100, stallreq_id=1 in the same cycle.
  - That cycle: redirect_valid_o=1, redirect_pc_o=0x80000100, stall_o=0.
  - flush_o=1 for exactly 3 cycles.
- Halt: halt_req pulse, then stallreq_id/flush_req toggled for 10 cycles -> stall_o=5'b11111 and halted_o=1 throughout; rst=1 returns to all 0.
- Watchdog with STALL_TIMEOUT=8: stallreq_ex=1 for 8 cycles -> timeout_err_o rises on cycle 9 and stays 1 after stallreq_ex drops.
  - With PIPE_CTRL_PERF_EN, stall_cycles_o=8 after this sequence.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage pipeline.
//
// Collects stall requests (ID load-use, ALU multi-cycle), ALU redirects and the
// WB halt. Drives per-register stall/bubble vectors, the front-end flush and the
// PC redirect. Tracks halt state, a flush extension counter and a stall watchdog.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stallreq_id        ID load-use hazard (level)
//   stallreq_ex        ALU busy (level, held until result ready)
//   flush_req/flush_pc ALU taken branch/jump pulse and its target
//   halt_req           ebreak retired in WB (pulse)
//   stall_o[4:0]       hold PC, IF_ID, ID_ALU, alu_mem, mem_wb
//   bubble_o[1:0]      NOP into ID_ALU, NOP into alu_mem
//   flush_o            clear IF_ID and ID_ALU
//   redirect_valid_o/redirect_pc_o  PC load strobe and target (target held)
//   halted_o           pipeline frozen until reset
//   timeout_err_o      sticky watchdog flag
//   stall_cycles_o/flush_count_o   perf counters
//
// Optional build macro PIPE_CTRL_PERF_EN enables the perf counters; when it is
// undefined both counter ports read 0 and no counter flops exist.
module pipe_ctrl #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned FLUSH_EXTRA   = 0,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            flush_req,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            halt_req,
  output logic [4:0]      stall_o,
  output logic [1:0]      bubble_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            halted_o,
  output logic            timeout_err_o,
  output logic [31:0]     stall_cycles_o,
  output logic [31:0]     flush_count_o
);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  localparam logic [3:0]  FlushExtra   = 4'(FLUSH_EXTRA);
  localparam logic [15:0] StallTimeout = 16'(STALL_TIMEOUT);

  state_e            state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [15:0]       wd_cnt_q, wd_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  // Ungated decode; the reset override is applied on the way to the ports.
  logic [4:0]        stall;
  logic [1:0]        bubble;
  logic              flush;
  logic              redirect_valid;

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    stall          = 5'b00000;
    bubble         = 2'b00;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      StRun, StFlush: begin
        flush = (state_q == StFlush);
        if (halt_req) begin
          stall   = 5'b11111;
          state_d = StHalt;
        end else if (stallreq_ex) begin
          // Flush counter is frozen while the ALU holds the pipe.
          stall  = 5'b00111;
          bubble = 2'b10;
        end else if (flush_req) begin
          // A concurrent load-use stall is dropped: its instruction is killed.
          flush          = 1'b1;
          redirect_valid = 1'b1;
          if (FlushExtra != 4'd0) begin
            state_d     = StFlush;
            flush_cnt_d = FlushExtra;
          end else begin
            state_d = StRun;
          end
        end else if (state_q == StFlush) begin
          if (flush_cnt_q <= 4'd1) begin
            state_d     = StRun;
            flush_cnt_d = 4'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end else if (stallreq_id) begin
          stall  = 5'b00011;
          bubble = 2'b01;
        end
      end
      StHalt: begin
        stall = 5'b11111;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Watchdog: counts consecutive ALU stall cycles, saturating at the timeout.
  always_comb begin
    wd_cnt_d = 16'd0;
    if (stallreq_ex) begin
      wd_cnt_d = (wd_cnt_q >= StallTimeout) ? wd_cnt_q : wd_cnt_q + 16'd1;
    end
    timeout_err_d = timeout_err_q | (wd_cnt_d == StallTimeout);
    redirect_pc_d = redirect_valid ? flush_pc : redirect_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      flush_cnt_q   <= 4'd0;
      wd_cnt_q      <= 16'd0;
      timeout_err_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Reset forces every output to 0, including the combinational decode.
  always_comb begin
    stall_o          = rst ? 5'b00000 : stall;
    bubble_o         = rst ? 2'b00 : bubble;
    flush_o          = ~rst & flush;
    redirect_valid_o = ~rst & redirect_valid;
    redirect_pc_o    = rst ? '0 : (redirect_valid ? flush_pc : redirect_pc_q);
    halted_o         = ~rst & (state_q == StHalt);
    timeout_err_o    = ~rst & timeout_err_q;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall[0] & (state_q != StHalt)};
    flush_count_d  = flush_count_q + {31'd0, redirect_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = rst ? 32'd0 : stall_cycles_q;
  assign flush_count_o  = rst ? 32'd0 : flush_count_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_EXTRA=2, STALL_TIMEOUT=8). Each step drives
// inputs after the falling edge, pushes the expected outputs to a scoreboard and
// pops/compares them once the combinational outputs have settled.
module tb_pipe_ctrl;

  localparam int unsigned XLEN = 32;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  stall;
    logic [1:0]  bubble;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        halted;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            stallreq_id;
  logic            stallreq_ex;
  logic            flush_req;
  logic [XLEN-1:0] flush_pc;
  logic            halt_req;
  logic [4:0]      stall_o;
  logic [1:0]      bubble_o;
  logic            flush_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            halted_o;
  logic            timeout_err_o;
  logic [31:0]     stall_cycles_o;
  logic [31:0]     flush_count_o;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [31:0] m_sc = 32'd0;
  logic [31:0] m_fc = 32'd0;

  exp_t  sb_q[$];
  string tag_q[$];

  pipe_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_EXTRA  (2),
    .STALL_TIMEOUT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id     (stallreq_id),
    .stallreq_ex     (stallreq_ex),
    .flush_req       (flush_req),
    .flush_pc        (flush_pc),
    .halt_req        (halt_req),
    .stall_o         (stall_o),
    .bubble_o        (bubble_o),
    .flush_o         (flush_o),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o   (redirect_pc_o),
    .halted_o        (halted_o),
    .timeout_err_o   (timeout_err_o),
    .stall_cycles_o  (stall_cycles_o),
    .flush_count_o   (flush_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [4:0] s, logic [1:0] b, logic f, logic rv,
                              logic [31:0] pc, logic hl, logic er);
    exp_t e;
    e.stall  = s;
    e.bubble = b;
    e.flush  = f;
    e.rv     = rv;
    e.rpc    = pc;
    e.halted = hl;
    e.err    = er;
    e.sc     = 32'd0;
    e.fc     = 32'd0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".stall"},    32'(stall_o),          32'(e.stall));
    check({t, ".bubble"},   32'(bubble_o),         32'(e.bubble));
    check({t, ".flush"},    32'(flush_o),          32'(e.flush));
    check({t, ".rvalid"},   32'(redirect_valid_o), 32'(e.rv));
    check({t, ".rpc"},      redirect_pc_o,         e.rpc);
    check({t, ".halted"},   32'(halted_o),         32'(e.halted));
    check({t, ".timeout"},  32'(timeout_err_o),    32'(e.err));
    check({t, ".stallcyc"}, stall_cycles_o,        e.sc);
    check({t, ".flushcnt"}, flush_count_o,         e.fc);
  endtask

  // Drive one cycle of stimulus, record its expectation, then compare.
  task automatic step(input string tag, input logic r, input logic id, input logic ex,
                      input logic fr, input logic [31:0] pc, input logic h, input exp_t e);
    exp_t ee;
    @(negedge clk);
    rst         = r;
    stallreq_id = id;
    stallreq_ex = ex;
    flush_req   = fr;
    flush_pc    = pc;
    halt_req    = h;
    ee          = e;
    if (r) begin
      m_sc = 32'd0;
      m_fc = 32'd0;
    end else begin
      ee.sc = PerfEn ? m_sc : 32'd0;
      ee.fc = PerfEn ? m_fc : 32'd0;
      m_sc  = m_sc + 32'((e.stall[0] && !e.halted) ? 1 : 0);
      m_fc  = m_fc + 32'(e.rv);
    end
    sb_q.push_back(ee);
    tag_q.push_back(tag);
    #2;
    compare_out();
  endtask

  initial begin
    exp_t z;
    z           = mk(5'b00000, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst         = 1'b1;
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    flush_req   = 1'b0;
    flush_pc    = '0;
    halt_req    = 1'b0;

    // Reset overrides every request.
    for (int i = 0; i < 3; i++) step("reset", 1, 1, 1, 1, 32'hDEADBEEF, 1, z);
    step("idle", 0, 0, 0, 0, 32'h0, 0, z);

    // Load-use stall, then release.
    step("ld_use", 0, 1, 0, 0, 32'h0, 0, mk(5'b00011, 2'b01, 0, 0, 32'h0, 0, 0));
    step("ld_use_rel", 0, 0, 0, 0, 32'h0, 0, z);

    // ALU busy dominates concurrent flush and load-use.
    for (int i = 0; i < 4; i++)
      step("alu_busy", 0, 1, 1, 1, 32'h0000_0040, 0, mk(5'b00111, 2'b10, 0, 0, 32'h0, 0, 0));
    step("alu_done", 0, 0, 0, 0, 32'h0, 0, z);

    // Redirect with concurrent load-use; flush held 1+2 cycles, ID ignored.
    step("redir", 0, 1, 0, 1, 32'h8000_0100, 0, mk(5'b00000, 2'b00, 1, 1, 32'h8000_0100, 0, 0));
    step("flush_x1", 0, 1, 0, 0, 32'h1234_5678, 0, mk(5'b00000, 2'b00, 1, 0, 32'h8000_0100, 0, 0));
    step("flush_x2", 0, 1, 0, 0, 32'h1234_5678, 0, mk(5'b00000, 2'b00, 1, 0, 32'h8000_0100, 0, 0));
    step("flush_end", 0, 0, 0, 0, 32'h1234_5678, 0, mk(5'b00000, 2'b00, 0, 0, 32'h8000_0100, 0, 0));
    step("post_flush_id", 0, 1, 0, 0, 32'h0, 0, mk(5'b00011, 2'b01, 0, 0, 32'h8000_0100, 0, 0));

    // Watchdog: 8 busy cycles trip the sticky timeout on the 9th.
    step("wd_reset", 1, 0, 0, 0, 32'h0, 0, z);
    for (int i = 0; i < 8; i++)
      step("wd_stall", 0, 0, 1, 0, 32'h0, 0, mk(5'b00111, 2'b10, 0, 0, 32'h0, 0, 0));
    step("wd_trip", 0, 0, 0, 0, 32'h0, 0, mk(5'b00000, 2'b00, 0, 0, 32'h0, 0, 1));
    step("wd_sticky", 0, 0, 0, 0, 32'h0, 0, mk(5'b00000, 2'b00, 0, 0, 32'h0, 0, 1));

    // Halt freezes everything until reset.
    step("halt_req", 0, 0, 0, 0, 32'h0, 1, mk(5'b11111, 2'b00, 0, 0, 32'h0, 0, 1));
    for (int i = 0; i < 10; i++)
      step("halted", 0, (i % 2 == 0), 0, (i % 2 == 1), 32'h4000_0000 + 32'(i), 0,
           mk(5'b11111, 2'b00, 0, 0, 32'h0, 1, 1));
    step("halt_rst", 1, 0, 0, 0, 32'h0, 0, z);
    step("after_rst", 0, 0, 0, 0, 32'h0, 0, z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
